// File: rtl/key_debounce_sel.sv
// Synchronises and debounces active-low keys, emits press/release/long pulses, steps a MODE register.
// Latency: 2 sync cycles + (DEB_TICKS-1)*TICK_DIV+1 .. DEB_TICKS*TICK_DIV cycles to KEY_LEVEL; MODE one cycle after PRESS.
// No backpressure: free-running, every output is a registered level or single-cycle pulse.
module key_debounce_sel #(
    parameter int KEY_W      = 4,
    parameter int TICK_DIV   = 48000,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000,
    parameter int MODE_W     = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [KEY_W-1:0]  KEY_N,
    output logic [KEY_W-1:0]  KEY_LEVEL,
    output logic [KEY_W-1:0]  KEY_PRESS,
    output logic [KEY_W-1:0]  KEY_RELEASE,
    output logic [KEY_W-1:0]  KEY_LONG,
    output logic [MODE_W-1:0] MODE
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int DEB_W  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_TICKS - 1);

    logic [KEY_W-1:0]  sync_a;
    logic [KEY_W-1:0]  sync_b;
    logic [KEY_W-1:0]  key_s;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [DEB_W-1:0]  deb_cnt  [KEY_W];
    logic [HOLD_W-1:0] hold_cnt [KEY_W];

    // Two-flop synchroniser; resets to all-ones so a reset looks like "all keys released"
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= KEY_N;
            sync_b <= sync_a;
        end
    end

    // Downstream logic only ever sees the active-high synchronised key
    assign key_s = ~sync_b;

    // Shared prescaler producing a one-cycle debounce tick every TICK_DIV cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = (pre_cnt == PRE_MAX);

    // Debounce: a changed key must stay changed for DEB_TICKS ticks; any bounce back restarts the count.
    // The edge pulses are raised in the same cycle the level changes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < KEY_W; i++) begin
                deb_cnt[i] <= '0;
            end
            KEY_LEVEL   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
        end else begin
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                if (key_s[i] == KEY_LEVEL[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (deb_cnt[i] == DEB_MAX) begin
                        KEY_LEVEL[i]   <= key_s[i];
                        KEY_PRESS[i]   <= key_s[i];
                        KEY_RELEASE[i] <= ~key_s[i];
                        deb_cnt[i]     <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end
            end
        end
    end

    // Long press: count ticks while held, saturate so KEY_LONG fires once per press
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < KEY_W; i++) begin
                hold_cnt[i] <= '0;
            end
            KEY_LONG <= '0;
        end else begin
            KEY_LONG <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                if (!KEY_LEVEL[i]) begin
                    hold_cnt[i] <= '0;
                end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                    KEY_LONG[i] <= (hold_cnt[i] == HOLD_ARM);
                end
            end
        end
    end

    // MODE steps up on key 0, down on key 1; simultaneous presses cancel out
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MODE <= '0;
        end else if (KEY_PRESS[0] && !KEY_PRESS[1]) begin
            MODE <= MODE + MODE_W'(1);
        end else if (KEY_PRESS[1] && !KEY_PRESS[0]) begin
            MODE <= MODE - MODE_W'(1);
        end
    end

endmodule
